// File: rtl/apu_reorder_queue_if.sv
// APU front-end bundle: core request/response, back-end issue and
// completion channels, plus status outputs of the reorder queue.
interface apu_reorder_queue_if #(
    parameter int DATA_W       = 32,
    parameter int NUM_OPERANDS = 3,
    parameter int OP_W         = 6,
    parameter int FLAGS_IN_W   = 15,
    parameter int FLAGS_OUT_W  = 5,
    parameter int DEPTH        = 4
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                                  apu_req;
    logic                                  apu_gnt;
    logic [NUM_OPERANDS-1:0][DATA_W-1:0]   apu_operands;
    logic [OP_W-1:0]                       apu_op;
    logic [FLAGS_IN_W-1:0]                 apu_flags_i;
    logic                                  apu_rvalid;
    logic [DATA_W-1:0]                     apu_result;
    logic [FLAGS_OUT_W-1:0]                apu_flags_o;

    logic                                  issue_valid;
    logic                                  issue_ready;
    logic [NUM_OPERANDS-1:0][DATA_W-1:0]   issue_operands;
    logic [OP_W-1:0]                       issue_op;
    logic [FLAGS_IN_W-1:0]                 issue_flags;
    logic [TAG_W-1:0]                      issue_tag;

    logic                                  cmpl_valid;
    logic [TAG_W-1:0]                      cmpl_tag;
    logic [DATA_W-1:0]                     cmpl_result;
    logic [FLAGS_OUT_W-1:0]                cmpl_flags;

    logic [TAG_W:0]                        occupancy;
    logic                                  protocol_err;

    modport slave (
        input  apu_req, apu_operands, apu_op, apu_flags_i,
        output apu_gnt, apu_rvalid, apu_result, apu_flags_o,
        output issue_valid, issue_operands, issue_op, issue_flags, issue_tag,
        input  issue_ready,
        input  cmpl_valid, cmpl_tag, cmpl_result, cmpl_flags,
        output occupancy, protocol_err
    );

    modport master (
        output apu_req, apu_operands, apu_op, apu_flags_i,
        input  apu_gnt, apu_rvalid, apu_result, apu_flags_o,
        input  issue_valid, issue_operands, issue_op, issue_flags, issue_tag,
        output issue_ready,
        output cmpl_valid, cmpl_tag, cmpl_result, cmpl_flags,
        input  occupancy, protocol_err
    );
endinterface

// File: rtl/apu_reorder_queue.sv
// In-order issue, out-of-order completion, in-order retire queue
// between the core APU port and the vector back-end.
module apu_reorder_queue #(
    parameter int DATA_W       = 32,
    parameter int NUM_OPERANDS = 3,
    parameter int OP_W         = 6,
    parameter int FLAGS_IN_W   = 15,
    parameter int FLAGS_OUT_W  = 5,
    parameter int DEPTH        = 4
) (
    input logic               clk,
    input logic               reset,
    apu_reorder_queue_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    typedef enum logic [1:0] {FREE, QUEUED, ISSUED, DONE} ent_state_t;

    ent_state_t                          state_q [DEPTH];
    ent_state_t                          state_d [DEPTH];
    logic [NUM_OPERANDS-1:0][DATA_W-1:0] ops_q   [DEPTH];
    logic [OP_W-1:0]                     op_q    [DEPTH];
    logic [FLAGS_IN_W-1:0]               flags_q [DEPTH];
    logic [DATA_W-1:0]                   res_q   [DEPTH];
    logic [FLAGS_OUT_W-1:0]              rflags_q[DEPTH];

    logic [TAG_W-1:0] alloc_ptr;
    logic [TAG_W-1:0] issue_ptr;
    logic [TAG_W-1:0] head_ptr;
    logic [TAG_W:0]   occ_q;
    logic             perr_q;
    logic             rvalid_q;
    logic [DATA_W-1:0]      result_q;
    logic [FLAGS_OUT_W-1:0] rflags_out_q;

    logic gnt;
    logic issue_fire;
    logic cmpl_ok;
    logic retire;

    // Grant looks at pre-retire occupancy so a full queue always denies.
    assign gnt        = bus.apu_req && (occ_q < DEPTH_C);
    assign issue_fire = bus.issue_valid && bus.issue_ready;
    assign cmpl_ok    = bus.cmpl_valid && (state_q[bus.cmpl_tag] == ISSUED);
    assign retire     = (state_q[head_ptr] == DONE);

    assign bus.apu_gnt        = gnt;
    assign bus.issue_valid    = (state_q[issue_ptr] == QUEUED);
    assign bus.issue_operands = ops_q[issue_ptr];
    assign bus.issue_op       = op_q[issue_ptr];
    assign bus.issue_flags    = flags_q[issue_ptr];
    assign bus.issue_tag      = issue_ptr;
    assign bus.apu_rvalid     = rvalid_q;
    assign bus.apu_result     = result_q;
    assign bus.apu_flags_o    = rflags_out_q;
    assign bus.occupancy      = occ_q;
    assign bus.protocol_err   = perr_q;

    // Each event targets an entry in a distinct state, so indices never clash.
    always_comb begin
        state_d = state_q;
        if (gnt)        state_d[alloc_ptr]    = QUEUED;
        if (issue_fire) state_d[issue_ptr]    = ISSUED;
        if (cmpl_ok)    state_d[bus.cmpl_tag] = DONE;
        if (retire)     state_d[head_ptr]     = FREE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
            alloc_ptr    <= '0;
            issue_ptr    <= '0;
            head_ptr     <= '0;
            occ_q        <= '0;
            perr_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            result_q     <= '0;
            rflags_out_q <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= retire;
            if (gnt)        alloc_ptr <= alloc_ptr + TAG_W'(1);
            if (issue_fire) issue_ptr <= issue_ptr + TAG_W'(1);
            if (retire) begin
                head_ptr     <= head_ptr + TAG_W'(1);
                result_q     <= res_q[head_ptr];
                rflags_out_q <= rflags_q[head_ptr];
            end
            if (gnt && !retire)      occ_q <= occ_q + (TAG_W+1)'(1);
            else if (!gnt && retire) occ_q <= occ_q - (TAG_W+1)'(1);
            if (bus.cmpl_valid && !cmpl_ok) perr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt) begin
            ops_q[alloc_ptr]   <= bus.apu_operands;
            op_q[alloc_ptr]    <= bus.apu_op;
            flags_q[alloc_ptr] <= bus.apu_flags_i;
        end
        if (cmpl_ok) begin
            res_q[bus.cmpl_tag]    <= bus.cmpl_result;
            rflags_q[bus.cmpl_tag] <= bus.cmpl_flags;
        end
    end
endmodule

// File: tb/tb_apu_reorder_queue.sv
// Bench for apu_reorder_queue: directed plan steps plus random traffic,
// checked cycle by cycle against an ordered-list reference model.
module tb_apu_reorder_queue;
    localparam int DATA_W = 32;
    localparam int NOPS   = 3;
    localparam int OP_W   = 6;
    localparam int FIW    = 15;
    localparam int FOW    = 5;
    localparam int DEPTH  = 4;
    localparam int OPSW   = NOPS * DATA_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apu_reorder_queue_if #(
        .DATA_W(DATA_W), .NUM_OPERANDS(NOPS), .OP_W(OP_W),
        .FLAGS_IN_W(FIW), .FLAGS_OUT_W(FOW), .DEPTH(DEPTH)
    ) bus ();

    apu_reorder_queue #(
        .DATA_W(DATA_W), .NUM_OPERANDS(NOPS), .OP_W(OP_W),
        .FLAGS_IN_W(FIW), .FLAGS_OUT_W(FOW), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // st: 0 queued, 1 issued, 2 done; list order is request order.
    typedef struct {
        int              tag;
        logic [OPSW-1:0] ops;
        logic [OP_W-1:0] op;
        logic [FIW-1:0]  flg;
        int              st;
        logic [DATA_W-1:0] res;
        logic [FOW-1:0]  rf;
    } ent_t;

    ent_t mq[$];
    int   alloc_cnt;
    bit   m_rv;
    logic [DATA_W-1:0] m_res;
    logic [FOW-1:0]    m_rf;
    bit   m_perr;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_queued();
        foreach (mq[i]) if (mq[i].st == 0) return i;
        return -1;
    endfunction

    function automatic int find_tag(int t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic idle();
        bus.apu_req      = 1'b0;
        bus.apu_operands = '0;
        bus.apu_op       = '0;
        bus.apu_flags_i  = '0;
        bus.issue_ready  = 1'b0;
        bus.cmpl_valid   = 1'b0;
        bus.cmpl_tag     = '0;
        bus.cmpl_result  = '0;
        bus.cmpl_flags   = '0;
    endtask

    task automatic rand_req();
        bus.apu_req      = 1'b1;
        bus.apu_operands = {$urandom, $urandom, $urandom};
        bus.apu_op       = OP_W'($urandom);
        bus.apu_flags_i  = FIW'($urandom);
    endtask

    task automatic complete(int t, logic [DATA_W-1:0] r);
        bus.cmpl_valid  = 1'b1;
        bus.cmpl_tag    = 2'(t);
        bus.cmpl_result = r;
        bus.cmpl_flags  = FOW'($urandom);
    endtask

    task automatic settle();
        int fq;
        #1;
        chk("occupancy", bus.occupancy, mq.size());
        chk("gnt", bus.apu_gnt, bus.apu_req && (mq.size() < DEPTH));
        chk("rvalid", bus.apu_rvalid, m_rv);
        chk("result", bus.apu_result, m_res);
        chk("flags_o", bus.apu_flags_o, m_rf);
        chk("protocol_err", bus.protocol_err, m_perr);
        fq = first_queued();
        chk("issue_valid", bus.issue_valid, fq >= 0);
        if (fq >= 0) begin
            chk("issue_tag", bus.issue_tag, mq[fq].tag);
            chk("issue_ops", bus.issue_operands, mq[fq].ops);
            chk("issue_op", bus.issue_op, mq[fq].op);
            chk("issue_flags", bus.issue_flags, mq[fq].flg);
        end
    endtask

    task automatic tick();
        int fq, ci, sz;
        bit ret;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            alloc_cnt = 0;
            m_rv = 0; m_res = '0; m_rf = '0; m_perr = 0;
        end else begin
            sz  = mq.size();
            ret = (sz > 0) && (mq[0].st == 2);
            fq  = first_queued();
            if (bus.cmpl_valid) begin
                ci = find_tag(int'(bus.cmpl_tag));
                if (ci >= 0 && mq[ci].st == 1) begin
                    mq[ci].st  = 2;
                    mq[ci].res = bus.cmpl_result;
                    mq[ci].rf  = bus.cmpl_flags;
                end else m_perr = 1;
            end
            if (fq >= 0 && bus.issue_ready) mq[fq].st = 1;
            m_rv = ret;
            if (ret) begin
                m_res = mq[0].res;
                m_rf  = mq[0].rf;
                void'(mq.pop_front());
            end
            if (bus.apu_req && sz < DEPTH) begin
                e.tag = alloc_cnt % DEPTH;
                e.ops = bus.apu_operands;
                e.op  = bus.apu_op;
                e.flg = bus.apu_flags_i;
                e.st  = 0;
                e.res = '0;
                e.rf  = '0;
                mq.push_back(e);
                alloc_cnt++;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() > 0 && n < 60) begin
            idle();
            bus.issue_ready = 1'b1;
            foreach (mq[i]) if (mq[i].st == 1) begin
                complete(mq[i].tag, $urandom);
                break;
            end
            step();
            n++;
        end
        idle();
        step();
        chk("drain_left", mq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [OPSW-1:0] first_ops;
        logic [DATA_W-1:0] got[$];
        logic [DATA_W-1:0] exp_ooo[3];
        int tg[3];
        int ord[3];
        int iss[$];
        int t;

        idle();
        reset = 1'b1;
        tick();
        step();
        reset = 1'b0;

        // single request round trip
        bus.apu_req = 1'b1;
        bus.apu_operands = {32'd3, 32'd2, 32'd1};
        bus.apu_op = 6'd5;
        settle();
        chk("t1_gnt", bus.apu_gnt, 1);
        tick();
        idle();
        bus.issue_ready = 1'b1;
        settle();
        chk("t1_issue_valid", bus.issue_valid, 1);
        chk("t1_issue_tag", bus.issue_tag, 0);
        chk("t1_issue_ops", bus.issue_operands, {32'd3, 32'd2, 32'd1});
        tick();
        idle();
        complete(0, 32'hA5);
        step();
        idle();
        step();
        settle();
        chk("t1_rvalid", bus.apu_rvalid, 1);
        chk("t1_result", bus.apu_result, 32'hA5);
        tick();
        settle();
        chk("t1_occ", bus.occupancy, 0);
        tick();

        // fill with back-end stalled
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_req();
            if (i == 0) first_ops = bus.apu_operands;
            settle();
            chk("fill_gnt", bus.apu_gnt, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            rand_req();
            settle();
            chk("fill_deny", bus.apu_gnt, 0);
            chk("stall_tag", bus.issue_tag, 0);
            chk("stall_ops", bus.issue_operands, first_ops);
            tick();
        end

        // full queue with head done: deny, then grant next cycle
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            bus.issue_ready = 1'b1;
            step();
        end
        idle();
        complete(mq[0].tag, 32'h77);
        step();
        idle();
        rand_req();
        settle();
        chk("full_head_done_deny", bus.apu_gnt, 0);
        tick();
        rand_req();
        settle();
        chk("after_retire_gnt", bus.apu_gnt, 1);
        tick();
        drain();

        // out-of-order completion
        for (int i = 0; i < 3; i++) begin
            idle();
            rand_req();
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.issue_ready = 1'b1;
            step();
        end
        for (int i = 0; i < 3; i++) tg[i] = mq[i].tag;
        ord = '{2, 0, 1};
        exp_ooo = '{32'h00, 32'h11, 32'h22};
        for (int k = 0; k < 9; k++) begin
            idle();
            if (k < 3) complete(tg[ord[k]], DATA_W'(ord[k] * 'h11));
            settle();
            if (bus.apu_rvalid) got.push_back(bus.apu_result);
            chk("ooo_early", bus.apu_rvalid && (k < 3), 0);
            tick();
        end
        chk("ooo_count", got.size(), 3);
        foreach (got[i]) if (i < 3) chk("ooo_order", got[i], exp_ooo[i]);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) rand_req();
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            iss.delete();
            foreach (mq[i]) if (mq[i].st == 1) iss.push_back(mq[i].tag);
            if (iss.size() > 0 && $urandom_range(0, 3) != 0)
                complete(iss[$urandom_range(0, iss.size() - 1)], $urandom);
            step();
        end
        drain();

        // illegal completions: FREE tag, then repeat on DONE tag
        idle();
        complete(0, 32'hDEAD);
        step();
        idle();
        settle();
        chk("perr_free", bus.protocol_err, 1);
        rand_req();
        t = alloc_cnt % DEPTH;
        tick();
        idle();
        bus.issue_ready = 1'b1;
        step();
        idle();
        complete(t, 32'h5A);
        step();
        idle();
        complete(t, 32'hEE);
        step();
        idle();
        settle();
        chk("dup_rvalid", bus.apu_rvalid, 1);
        chk("dup_result", bus.apu_result, 32'h5A);
        chk("perr_sticky", bus.protocol_err, 1);
        tick();

        // reset with entries in flight
        for (int i = 0; i < 3; i++) begin
            idle();
            rand_req();
            bus.issue_ready = 1'b1;
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_rvalid", bus.apu_rvalid, 0);
        chk("rst_perr", bus.protocol_err, 0);
        tick();
        complete(1, 32'h1);
        step();
        idle();
        settle();
        chk("stale_cmpl_perr", bus.protocol_err, 1);
        tick();
        rand_req();
        step();
        idle();
        settle();
        chk("post_rst_valid", bus.issue_valid, 1);
        chk("post_rst_tag", bus.issue_tag, 0);
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apu_reorder_queue.md
# apu_reorder_queue

Parametrised APU front-end for the vector accelerator. It sits between the core's APU request/response port and the vector execution back-end (decoder, vector registers, arith stage). It accepts up to DEPTH outstanding APU requests and issues them in order over a valid/ready channel. It accepts completions from the back-end in any order by tag and returns results to the core strictly in request order.

## Interface

Parameters:
- DATA_W, 32, operand/result width
- NUM_OPERANDS, 3, operands per request
- OP_W, 6, apu_op width
- FLAGS_IN_W, 15, apu_flags_i width
- FLAGS_OUT_W, 5, apu_flags_o width
- DEPTH, 4, queue entries; power of 2, ≥2; TAG_W = $clog2(DEPTH)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- apu_req  in  1  core request
- apu_gnt  out  1  request accepted this cycle
- apu_operands  in  NUM_OPERANDS×DATA_W  request operands
- apu_op  in  OP_W  operation code
- apu_flags_i  in  FLAGS_IN_W  request flags
- apu_rvalid  out  1  result valid, one-cycle pulse
- apu_result  out  DATA_W  result
- apu_flags_o  out  FLAGS_OUT_W  result flags
- issue_valid  out  1  entry offered to back-end
- issue_ready  in  1  back-end accepts
- issue_operands  out  NUM_OPERANDS×DATA_W  stored operands
- issue_op  out  OP_W  stored op
- issue_flags  out  FLAGS_IN_W  stored flags
- issue_tag  out  TAG_W  entry index
- cmpl_valid  in  1  back-end completion
- cmpl_tag  in  TAG_W  completing entry
- cmpl_result  in  DATA_W  completion result
- cmpl_flags  in  FLAGS_OUT_W  completion flags
- occupancy  out  TAG_W+1  allocated entries
- protocol_err  out  1  sticky: illegal completion seen

## Operation

- Circular buffer of DEPTH entries with pointers alloc_ptr, issue_ptr, and head_ptr. Pointers wrap modulo DEPTH.
- Per-entry state: FREE → QUEUED (alloc) → ISSUED (issue handshake) → DONE (completion) → FREE (retire).
- Grant: apu_gnt = apu_req && occupancy < DEPTH. This is combinational, in the same cycle as the request. When apu_gnt is high, operands, op and flags are written at alloc_ptr, the entry goes to QUEUED, and alloc_ptr increments.
- Issue: issue_valid = state[issue_ptr] == QUEUED. issue_* are driven from that entry, and issue_tag = issue_ptr. On issue_valid && issue_ready the entry goes to ISSUED and issue_ptr increments. issue_* must stay stable while valid && !ready.
- Completion: on cmpl_valid with state[cmpl_tag] == ISSUED, result and flags are stored and the entry goes to DONE.
  - If the entry is in any other state, the completion is ignored and protocol_err is set. protocol_err is cleared only by reset.
- Retire: when state[head_ptr] == DONE, the queue retires that entry:
  - apu_rvalid, apu_result and apu_flags_o are registered high/loaded for the next cycle.
  - The entry goes to FREE and head_ptr increments.
  - At most one retire per cycle. The core has no backpressure, so a retire always completes.
- Occupancy: +1 on grant, −1 on retire, unchanged when both happen in the same cycle. Grant uses the occupancy value from before the same-cycle retire, so a full queue denies even while a retire is pending.
- Allocation and retire of the same index in one cycle is impossible (full denies).
- Reset:
  - All entries go to FREE, all pointers to 0, occupancy 0, protocol_err 0.
  - apu_rvalid, apu_result, apu_flags_o and issue_valid all go to 0.
  - In-flight entries are discarded. Completions arriving afterwards target FREE entries, so they are ignored and set protocol_err.

## Timing

- Request granted in cycle 0 → entry QUEUED in cycle 1 → issue_valid in cycle 1 at the earliest.
- Issue handshake in cycle i → a completion for that tag is legal from cycle i+1.
- Completion in cycle c → entry DONE in cycle c+1 → apu_rvalid high in cycle c+2 if it is the head.
- Minimum round trip: request in cycle 0, apu_rvalid in cycle 4.
- Sustained throughput: one grant, one issue, one completion and one retire per cycle.
- apu_rvalid is high for exactly one cycle per retire. apu_result and apu_flags_o hold their last value when rvalid is low.
- No combinational path from cmpl_* or issue_ready to any apu_* output. The only combinational path is apu_req → apu_gnt.

## Test plan

- Single request, ops=(1,2,3), op=5:
  - gnt in cycle 0; issue_valid in cycle 1 with tag 0 and operands (1,2,3).
  - ready in cycle 1, completion tag 0 result 0xA5 in cycle 2 → apu_rvalid in cycle 4 with result 0xA5.
  - occupancy returns to 0.
- Fill with DEPTH=4 and issue_ready=0:
  - 4 grants, then the 5th request is denied (apu_gnt=0).
  - issue_valid stays high with tag 0 and stable issue_* throughout the stall.
- Out-of-order completion, 3 issued requests completing with tags 2, 0, 1 and results 0x22, 0x00, 0x11:
  - apu_rvalid pulses return 0x00, 0x11, 0x22 in that order.
  - No result is returned before tag 0 completes.
- Full queue with the head DONE and a request present: no grant in that cycle; grant in the following cycle.
- Completion for a FREE tag and a repeated completion for a DONE tag:
  - Both are ignored; protocol_err goes to 1 and stays 1.
  - The stored result is unchanged.
- Reset with 3 entries in flight:
  - Next cycle: occupancy 0, issue_valid 0, apu_rvalid 0.
  - A later completion for tag 1 sets protocol_err.
  - A new request is issued with tag 0.
